// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter that merges the in-order ALU pipeline write
// with the multi-cycle mult/div unit onto one register-file write port.
// The ALU always wins; MD results wait in a small in-order queue.
// Optional macro WB_TRACE_EN: prints one trace line per register-file write
// (simulation only); with the macro undefined the function is unchanged.
module wb_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_a3,
  input  logic [31:0] alu_wd,
  input  logic [31:0] alu_pc,
  input  logic        md_valid,
  input  logic [4:0]  md_a3,
  input  logic [31:0] md_wd,
  input  logic [31:0] md_pc,
  output logic        md_ready,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc,
  output logic        md_pend
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned EW = AW + 2 * DW;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [EW-1:0] q_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  logic          alu_wr;
  logic          md_acc;
  logic          q_empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // a3 == 0 means "no write"; ready depends on occupancy only
  assign alu_wr   = alu_valid && (alu_a3 != AW'(0));
  assign md_ready = (count != CW'(DEPTH));
  assign md_acc   = md_valid && md_ready && (md_a3 != AW'(0));
  assign q_empty  = (count == CW'(0));
  assign head     = q_mem[rd_ptr];

  // Queue control: pop when the port is free, push MD results that cannot bypass
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    count_nxt = count;
    if (alu_wr) begin
      push = md_acc;
    end else if (!q_empty) begin
      pop  = 1'b1;
      push = md_acc;
    end
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  // Queue storage; contents are don't-care while count marks them invalid
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      q_mem[wr_ptr] <= {md_a3, md_wd, md_pc};
    end
  end

  // Pointers, occupancy and the registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= PW'(0);
      wr_ptr  <= PW'(0);
      count   <= CW'(0);
      md_pend <= 1'b0;
      grf_we  <= 1'b0;
      grf_a3  <= AW'(0);
      grf_wd  <= DW'(0);
      grf_pc  <= DW'(0);
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count   <= count_nxt;
      md_pend <= (count_nxt != CW'(0));
      grf_we  <= 1'b0;
      if (alu_wr) begin
        grf_we <= 1'b1;
        grf_a3 <= alu_a3;
        grf_wd <= alu_wd;
        grf_pc <= alu_pc;
      end else if (!q_empty) begin
        grf_we <= 1'b1;
        {grf_a3, grf_wd, grf_pc} <= head;
      end else if (md_acc) begin
        grf_we <= 1'b1;
        grf_a3 <= md_a3;
        grf_wd <= md_wd;
        grf_pc <= md_pc;
      end
    end
  end

`ifdef WB_TRACE_EN
  // Trace each register-file write as it appears on the port
  always_ff @(posedge clk) begin
    if (grf_we) begin
      $display("@%08h: $%0d <= %08h", grf_pc, grf_a3, grf_wd);
    end
  end
`else
`endif

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter: DEPTH, default 2, MD result queue depth (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have ports: alu_valid / alu_a3 / alu_wd / alu_pc  input  1/5/32/32  in-order pipeline write request; never stalled.
REQ-005 SHALL have ports: md_valid / md_a3 / md_wd / md_pc  input  1/5/32/32  multi-cycle mult/div unit write request.
REQ-006 SHALL have port: md_ready  output  1  queue can accept an MD request this cycle.
REQ-007 SHALL have ports: grf_we / grf_a3 / grf_wd  output  1/5/32  single register-file write port (WE, A3, WD).
REQ-008 SHALL have port: grf_pc  output  32  PC of the instruction being written back.
REQ-009 SHALL have port: md_pend  output  1  at least one MD result queued, not yet written.

Function
REQ-010 SHALL treat any request with a3==0 as absent: never written, never queued; md_ready unaffected.
REQ-011 SHALL register all grf_* outputs; an accepted request appears on grf_* exactly 1 cycle after acceptance at the earliest.
REQ-012 SHALL accept an MD request on cycle where md_valid && md_ready (handshake); md_ready = queue not full, combinational from state only (not from md_valid).
REQ-013 SHALL give ALU absolute priority: alu_valid with a3!=0 -> next cycle grf_we=1 with ALU a3/wd/pc.
REQ-014 SHALL, when no ALU write: if queue non-empty, issue queue head and pop; else if MD accepted this cycle, bypass it directly to grf_* next cycle (not enqueued).
REQ-015 SHALL, when ALU writes and an MD request is accepted same cycle, enqueue the MD request.
REQ-016 SHALL issue queued MD results strictly in acceptance order; no result dropped or duplicated.
REQ-017 SHALL allow simultaneous pop and push on same cycle when full-condition permits (push gated by md_ready of that cycle).
REQ-018 SHALL use wrapping read/write pointers of log2(DEPTH) bits plus an occupancy count 0..DEPTH; full = count==DEPTH, empty = count==0.
REQ-019 SHALL drive grf_we=0 on any cycle with nothing issued; grf_a3/wd/pc then hold previous values.
REQ-020 SHALL drive md_pend = (count != 0), registered state.
REQ-021 SHALL not resolve RAW/WAW ordering between ALU and MD writes; the hazard unit stalls on md_pend.

Reset
REQ-022 SHALL on reset: grf_we=0, grf_a3=0, grf_wd=0, grf_pc=0, count=0, pointers=0, md_pend=0, md_ready=1 next cycle.
REQ-023 SHALL on reset mid-operation discard all queued results and any same-cycle requests; reset overrides all.

Configuration
REQ-024 SHALL, with macro WB_TRACE_EN defined, print on every cycle with grf_we=1 the line "@<pc hex>: $<a3 decimal> <= <wd hex>" (simulation only).
REQ-025 SHALL, without WB_TRACE_EN, contain no display statements; function identical.

Verification
REQ-026 SHALL cover: alu_valid=1,a3=5,wd=0x1234,pc=0x3000 -> next cycle grf_we=1,a3=5,wd=0x1234,pc=0x3000.
REQ-027 SHALL cover: alu_valid=0, md_valid=1,a3=8,wd=0xABCD, queue empty -> next cycle grf_we=1,a3=8; md_pend stays 0.
REQ-028 SHALL cover: ALU writes a3=1,2,3 on 3 consecutive cycles while MD pushes a3=9 (wd=0x9) then a3=10 (wd=0xA) on the first two -> ALU writes issue cycles 1-3, md_ready=0 on cycle 2 (DEPTH=2 full), MD writes issue in order a3=9 then 10 on cycles 4-5, md_pend clears after.
REQ-029 SHALL cover: alu a3=0 wd=0xFFFF and md a3=0 -> grf_we stays 0, queue unchanged.
REQ-030 SHALL cover: queue holding 2 entries, reset asserted 1 cycle -> grf_we=0, md_pend=0, md_ready=1; queued results never written.
REQ-031 SHALL cover: WB_TRACE_EN defined, write a3=31 wd=0x00400000 pc=0x3008 -> one trace line "@00003008: $31 <= 00400000".
